pipeline_trace_buffer: RTL and testbench

Synthesizable instruction-trace capture unit for the 5-stage MIPS pipeline. It records one (PC, instruction, timestamp) entry per advancing fetch cycle into a parametrised circular buffer, with an optional PC-match trigger and a post-trigger window. Captured history drains oldest-first over a valid/ready stream. It is the on-chip replacement for bench-side `$monitor` tracing of the fetch stage, and hangs off the IF-stage PC and instruction signals.

---
 rtl/pipeline_trace_buffer.sv | 138 +++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// Fetch-stage trace capture into a DEPTH-entry ring with a PC trigger and post-trigger window.
// Writes land on the sampling edge. Oldest-first drain in DONE, one entry per rd_valid&rd_ready cycle.
module pipeline_trace_buffer #(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     sample_valid,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [INSTR_W-1:0]       rd_instr,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t cur, nxt;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [TS_W-1:0]    ts_mem    [DEPTH];

  logic [AW-1:0]   wptr, rptr;
  logic [AW-1:0]   post_cnt;
  logic [TS_W-1:0] ts;
  logic            capturing, wr, trig_hit, pop, full;

  assign capturing = (cur == CAPTURE) || (cur == POST);
  assign wr        = capturing && sample_valid && !arm;
  assign trig_hit  = (cur == CAPTURE) && trig_en && sample_valid && (pc_in == trig_pc);
  assign pop       = (cur == DONE) && (count != '0) && rd_ready && !arm;
  assign full      = (count == CW'(DEPTH));

  assign rd_valid = (cur == DONE) && (count != '0);
  assign rd_pc    = pc_mem[rptr];
  assign rd_instr = instr_mem[rptr];
  assign rd_ts    = ts_mem[rptr];
  assign state    = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= IDLE;
    else        cur <= nxt;
  end

  // stop outranks a same-cycle trigger; the sample itself is still written
  always_comb begin
    nxt = cur;
    if (arm) begin
      nxt = CAPTURE;
    end else begin
      case (cur)
        CAPTURE: begin
          if (stop)          nxt = DONE;
          else if (trig_hit) nxt = (POST_TRIG == 0) ? DONE : POST;
        end
        POST: begin
          if (stop || (wr && post_cnt == AW'(1))) nxt = DONE;
        end
        DONE: begin
          if (pop && count == CW'(1)) nxt = IDLE;
        end
        default: nxt = cur;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else if (arm) begin
      ts       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else begin
      if (capturing) ts <= ts + TS_W'(1);
      if (wr) begin
        wptr <= wptr + AW'(1);
        // a full ring drops its oldest entry so the read side tracks the new oldest
        if (full) begin
          overflow <= 1'b1;
          rptr     <= rptr + AW'(1);
        end else begin
          count <= count + CW'(1);
        end
      end else if (pop) begin
        rptr  <= rptr + AW'(1);
        count <= count - CW'(1);
      end
      if (trig_hit && !stop)    post_cnt <= AW'(POST_TRIG);
      else if (cur == POST && wr) post_cnt <= post_cnt - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        ts_mem[i]    <= '0;
      end
    end else if (wr) begin
      pc_mem[wptr]    <= pc_in;
      instr_mem[wptr] <= instr_in;
      ts_mem[wptr]    <= ts;
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer: scenario table plus hand-written corner sequences.
module tb_pipeline_trace_buffer;

  logic        clk = 1'b0, reset = 1'b0, arm = 1'b0, stop = 1'b0;
  logic        sample_valid = 1'b0, trig_en = 1'b0, rd_ready = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0, trig_pc = '0;
  logic        rd_valid, overflow;
  logic [31:0] rd_pc, rd_instr;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] ts;
  } ent_t;

  typedef struct {
    int          n;
    bit          stall;
    bit          ten;
    logic [31:0] tpc;
    bit          do_stop;
    int          exp_count;
    bit          exp_ovf;
  } vec_t;

  ent_t sb[$];
  vec_t vt[4];

  always #5 clk = ~clk;

  pipeline_trace_buffer dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .sample_valid(sample_valid),
    .pc_in(pc_in), .instr_in(instr_in), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_ts(rd_ts), .count(count), .overflow(overflow), .state(state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    sb.delete();
  endtask

  task automatic drive(input logic [31:0] pc, input bit sv);
    pc_in        = pc;
    instr_in     = 32'hC0DE_0000 ^ pc;
    sample_valid = sv;
    step();
  endtask

  // Pops the scoreboard against the DUT read port; optionally stalls one cycle per entry.
  task automatic drain_all(input string tag, input bit toggle);
    ent_t e;
    int   guard;
    guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      e = sb.pop_front();
      chk({tag, ".rd_valid"}, rd_valid, 1);
      chk({tag, ".rd_pc"}, rd_pc, e.pc);
      chk({tag, ".rd_instr"}, rd_instr, e.instr);
      chk({tag, ".rd_ts"}, rd_ts, e.ts);
      if (toggle) begin
        rd_ready = 1'b0;
        step();
        chk({tag, ".hold_pc"}, rd_pc, e.pc);
        chk({tag, ".hold_ts"}, rd_ts, e.ts);
        chk({tag, ".hold_count"}, count, sb.size() + 1);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      guard++;
    end
    chk({tag, ".idle_after_drain"}, state, 0);
    chk({tag, ".rd_valid_after_drain"}, rd_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] ts;
    bit          cap, sv;
    int          post;
    string       tag;
    tag  = $sformatf("vec%0d", idx);
    ts   = '0;
    cap  = 1'b1;
    post = -1;
    do_arm();
    chk({tag, ".armed_state"}, state, 1);
    chk({tag, ".armed_count"}, count, 0);
    trig_en = v.ten;
    trig_pc = v.tpc;
    for (int i = 0; i < v.n; i++) begin
      sv = v.stall ? (i % 2 == 0) : 1'b1;
      drive(32'(i * 4), sv);
      if (cap) begin
        if (sv) begin
          sb.push_back('{pc_in, instr_in, ts});
          if (sb.size() > 16) sb.delete(0);
          if (post > 0) begin
            post--;
            if (post == 0) cap = 1'b0;
          end else if (v.ten && pc_in == v.tpc) begin
            post = 4;
          end
        end
        ts++;
      end
    end
    sample_valid = 1'b0;
    trig_en      = 1'b0;
    if (v.do_stop) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
    chk({tag, ".done_state"}, state, 3);
    chk({tag, ".count"}, count, v.exp_count);
    chk({tag, ".overflow"}, overflow, v.exp_ovf);
    drain_all(tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //         n  stall ten tpc       stop cnt ovf
    vt[0] = '{5,  1'b0, 1'b0, 32'h00, 1'b1, 5,  1'b0};
    vt[1] = '{20, 1'b0, 1'b0, 32'h00, 1'b1, 16, 1'b1};
    vt[2] = '{16, 1'b0, 1'b1, 32'h20, 1'b0, 13, 1'b0};
    vt[3] = '{8,  1'b1, 1'b1, 32'h04, 1'b1, 4,  1'b0};

    #2;
    chk("reset.state", state, 0);
    chk("reset.count", count, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.rd_valid", rd_valid, 0);
    chk("reset.rd_pc", rd_pc, 0);
    chk("reset.rd_ts", rd_ts, 0);
    #1 reset = 1'b1;
    step();

    for (int k = 0; k < 4; k++) run_vec(vt[k], k);

    // stop and trigger together: DONE wins, then drain under back-pressure
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h20;
    drive(32'h00, 1'b1);
    sb.push_back('{32'h00, 32'hC0DE_0000, 16'd0});
    drive(32'h04, 1'b1);
    sb.push_back('{32'h04, 32'hC0DE_0004, 16'd1});
    stop = 1'b1;
    drive(32'h20, 1'b1);
    sb.push_back('{32'h20, 32'hC0DE_0020, 16'd2});
    stop = 1'b0;
    sample_valid = 1'b0;
    trig_en = 1'b0;
    chk("stoptrig.state", state, 3);
    chk("stoptrig.count", count, 3);
    drain_all("stoptrig", 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop.state", state, 0);

    // asynchronous reset while in the post-trigger window
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h20;
    drive(32'h20, 1'b1);
    chk("post.state", state, 2);
    drive(32'h24, 1'b1);
    sample_valid = 1'b0;
    trig_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset.state", state, 0);
    chk("midreset.count", count, 0);
    chk("midreset.overflow", overflow, 0);
    chk("midreset.rd_valid", rd_valid, 0);
    chk("midreset.rd_pc", rd_pc, 0);
    chk("midreset.rd_instr", rd_instr, 0);
    chk("midreset.rd_ts", rd_ts, 0);
    #1 reset = 1'b1;
    step();

    // overflowed capture, partial drain, stop ignored in DONE, then re-arm
    do_arm();
    for (int i = 0; i < 17; i++) begin
      drive(32'(i * 4), 1'b1);
      if (i > 0) sb.push_back('{pc_in, instr_in, 16'(i)});
    end
    sample_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("rearm.pre_count", count, 16);
    chk("rearm.pre_overflow", overflow, 1);
    for (int k = 0; k < 13; k++) begin
      ent_t e;
      e = sb.pop_front();
      chk("rearm.drain_pc", rd_pc, e.pc);
      chk("rearm.drain_ts", rd_ts, e.ts);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    chk("rearm.left_count", count, 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("done_stop.state", state, 3);
    chk("done_stop.count", count, 3);
    arm = 1'b1;
    rd_ready = 1'b1;
    step();
    arm = 1'b0;
    rd_ready = 1'b0;
    chk("rearm.state", state, 1);
    chk("rearm.count", count, 0);
    chk("rearm.overflow", overflow, 0);
    chk("rearm.rd_valid", rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
